// File: rtl/dec_arb_pkg.sv
// Shared types, default sizing and helpers for the decode-path round-robin arbiter.
// The MSB-first encoder matches the existing 32-bit priority encoder's index encoding.
package dec_arb_pkg;

  localparam int unsigned MaxN        = 32;
  localparam int unsigned DefN        = 32;
  localparam int unsigned DefW        = 5;
  localparam int unsigned DefHoldMax  = 255;

  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbGrant   = 2'd1,
    ArbRelease = 2'd2
  } arb_state_t;

  function automatic logic [MaxN-1:0] onehot(input logic [4:0] idx);
    logic [MaxN-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Later (higher) set bits overwrite earlier ones, so the MSB wins.
  function automatic logic [4:0] prio_msb(input logic [MaxN-1:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MaxN; i++) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dec_rr_pick.sv
// Rotating-mask pick: highest requester strictly below last_idx, else highest overall.
module dec_rr_pick
  import dec_arb_pkg::*;
#(
  parameter int unsigned N = DefN,
  parameter int unsigned W = DefW
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_idx_i,
  output logic [W-1:0] pick_idx_o,
  output logic         any_req_o
);

  logic [MaxN-1:0] req_pad;
  logic [MaxN-1:0] masked_pad;
  logic [4:0]      pick_full;
  logic [4:0]      pick_masked;
  logic [4:0]      pick_sel;

  always_comb begin
    req_pad    = '0;
    masked_pad = '0;
    for (int i = 0; i < int'(N); i++) begin
      req_pad[i]    = req_i[i];
      masked_pad[i] = req_i[i] & (i < int'(last_idx_i));
    end
  end

  always_comb begin
    pick_full   = prio_msb(req_pad);
    pick_masked = prio_msb(masked_pad);
    pick_sel    = (|masked_pad) ? pick_masked : pick_full;
  end

  assign pick_idx_o = pick_sel[W-1:0];
  assign any_req_o  = |req_i;

endmodule

// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter for the shared decode datapath: one registered grant at a time,
// released on done, request drop or hold timeout, with a one-cycle turnaround gap.
module dec_rr_arbiter
  import dec_arb_pkg::*;
#(
  parameter int unsigned N        = DefN,
  parameter int unsigned W        = DefW,
  parameter int unsigned HOLD_MAX = DefHoldMax
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         done_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] grant_idx_o,
  output logic         grant_valid_o,
  output logic         timeout_o
);

  localparam logic [1:0] StIdle    = ArbIdle;
  localparam logic [1:0] StGrant   = ArbGrant;
  localparam logic [1:0] StRelease = ArbRelease;

  // With the timeout disabled the counter just saturates at all-ones.
  localparam int unsigned     CntW    = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 8;
  localparam logic [CntW-1:0] CntSat  = (HOLD_MAX > 0) ? CntW'(HOLD_MAX) : {CntW{1'b1}};
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD_MAX - 1);

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [W-1:0]    idx_q, idx_d;
  logic [W-1:0]    last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic [W-1:0]    pick_idx;
  logic            any_req;
  logic [MaxN-1:0] pick_oh;
  logic            owner_req;
  logic            hit_timeout;
  logic            do_release;

  dec_rr_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .req_i      (req_i),
    .last_idx_i (last_q),
    .pick_idx_o (pick_idx),
    .any_req_o  (any_req)
  );

  assign pick_oh     = onehot(5'(pick_idx));
  assign owner_req   = req_i[idx_q];
  assign hit_timeout = (HOLD_MAX != 0) && (cnt_q == CntLast);
  assign do_release  = done_i || !owner_req || hit_timeout;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle, StRelease: begin
        if (any_req) begin
          state_d = StGrant;
          grant_d = pick_oh[N-1:0];
          idx_d   = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        if (do_release) begin
          state_d   = StRelease;
          grant_d   = '0;
          idx_d     = '0;
          cnt_d     = '0;
          // Timeout is only blamed when the owner still wanted the resource.
          timeout_d = hit_timeout && !done_i && owner_req;
        end else if (cnt_q != CntSat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = idx_q;
  assign grant_valid_o = |grant_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Directed bench for dec_rr_arbiter: a default instance plus a HOLD_MAX=4 instance.
module tb_dec_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] req;
  logic        done;
  logic [31:0] grant;
  logic [4:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  logic [31:0] req_t;
  logic        done_t;
  logic [31:0] grant_t;
  logic [4:0]  grant_idx_t;
  logic        grant_valid_t;
  logic        timeout_t;

  int total = 0;
  int bad   = 0;

  dec_rr_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req),
    .done_i        (done),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid),
    .timeout_o     (timeout)
  );

  dec_rr_arbiter #(
    .N        (32),
    .W        (5),
    .HOLD_MAX (4)
  ) dut_t (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_t),
    .done_i        (done_t),
    .grant_o       (grant_t),
    .grant_idx_o   (grant_idx_t),
    .grant_valid_o (grant_valid_t),
    .timeout_o     (timeout_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [31:0] eg, input logic [4:0] ei,
                          input logic ev, input logic et);
    chk({tag, ".grant"}, grant, eg);
    chk({tag, ".idx"}, 32'(grant_idx), 32'(ei));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(ev));
    chk({tag, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic chk_t(input string tag, input logic [31:0] eg, input logic [4:0] ei,
                       input logic ev, input logic et);
    chk({tag, ".grant"}, grant_t, eg);
    chk({tag, ".idx"}, 32'(grant_idx_t), 32'(ei));
    chk({tag, ".valid"}, 32'(grant_valid_t), 32'(ev));
    chk({tag, ".timeout"}, 32'(timeout_t), 32'(et));
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    done   = 1'b0;
    req_t  = '0;
    done_t = 1'b0;
    tick();
    tick();
    chk_main("reset", 32'h0, 5'd0, 1'b0, 1'b0);
    chk_t("reset_t", 32'h0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_main("idle", 32'h0, 5'd0, 1'b0, 1'b0);

    // Single request on bit 4.
    req = 32'h10;
    tick();
    chk_main("single", 32'h10, 5'd4, 1'b1, 1'b0);
    tick();
    chk_main("single_hold", 32'h10, 5'd4, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk_main("single_rel", 32'h0, 5'd0, 1'b0, 1'b0);
    done = 1'b0;
    req  = '0;
    tick();
    chk_main("single_idle", 32'h0, 5'd0, 1'b0, 1'b0);

    // Masked wrap: last=3 with req 0x108 wraps to 8, then back to 3.
    req = 32'h8;
    tick();
    chk_main("wrap_g3", 32'h8, 5'd3, 1'b1, 1'b0);
    done = 1'b1;
    req  = 32'h108;
    tick();
    chk_main("wrap_gap1", 32'h0, 5'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    chk_main("wrap_g8", 32'h100, 5'd8, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk_main("wrap_gap2", 32'h0, 5'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    chk_main("wrap_back3", 32'h8, 5'd3, 1'b1, 1'b0);

    // Request drop: move to idx 7, then drop req[7] without done.
    done = 1'b1;
    req  = 32'h80;
    tick();
    chk_main("drop_gap", 32'h0, 5'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    chk_main("drop_g7", 32'h80, 5'd7, 1'b1, 1'b0);
    req = '0;
    tick();
    chk_main("drop_rel", 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    chk_main("drop_idle", 32'h0, 5'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant.
    req = 32'h1;
    tick();
    chk_main("rst_pre", 32'h1, 5'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    chk_main("rst_async", 32'h0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_main("rst_regrant", 32'h1, 5'd0, 1'b1, 1'b0);
    req = '0;
    tick();
    tick();
    chk_main("rst_idle", 32'h0, 5'd0, 1'b0, 1'b0);

    // Rotation with every requester active and done on each grant.
    req = 32'hFFFF_FFFF;
    tick();
    for (int k = 31; k >= 0; k--) begin
      chk_main($sformatf("rot%0d", k), 32'h1 << k, 5'(k), 1'b1, 1'b0);
      done = 1'b1;
      tick();
      chk_main($sformatf("rot_gap%0d", k), 32'h0, 5'd0, 1'b0, 1'b0);
      done = 1'b0;
      tick();
    end
    chk_main("rot_wrap31", 32'h8000_0000, 5'd31, 1'b1, 1'b0);
    req = '0;
    tick();

    // Timeout on the HOLD_MAX=4 instance.
    req_t = 32'h1;
    tick();
    chk_t("to_g0", 32'h1, 5'd0, 1'b1, 1'b0);
    for (int c = 1; c < 4; c++) begin
      tick();
      chk_t($sformatf("to_hold%0d", c), 32'h1, 5'd0, 1'b1, 1'b0);
    end
    tick();
    chk_t("to_fire", 32'h0, 5'd0, 1'b0, 1'b1);
    tick();
    chk_t("to_regrant", 32'h1, 5'd0, 1'b1, 1'b0);
    // done on the timeout cycle suppresses the pulse.
    tick();
    tick();
    tick();
    done_t = 1'b1;
    tick();
    chk_t("to_done_rel", 32'h0, 5'd0, 1'b0, 1'b0);
    done_t = 1'b0;
    req_t  = '0;
    tick();
    chk_t("to_idle", 32'h0, 5'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
